sm_para_3_wdt: RTL

//  3-paragraph (state reg / next-state / registered outputs) successor of the i1/i2 protocol FSM.

---
 rtl/sm_para_3_wdt_pkg.sv | 33 +++
 rtl/sm_para_3_wdt_if.sv | 24 ++
 rtl/sm_para_3_wdt_dwell_timer.sv | 30 +++
 rtl/sm_para_3_wdt.sv | 110 +++++++++++
 4 files changed

// File: rtl/sm_para_3_wdt_pkg.sv
// Shared state codes and output decode for the sm_para_3_wdt protocol FSM.
package sm_para_3_wdt_pkg;

    localparam int unsigned STATE_W = 2;
    localparam int unsigned OUT_W   = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'b00,
        S1    = 2'b01,
        S2    = 2'b10,
        ERROR = 2'b11
    } state_e;

    // {o1, o2, err} for each state
    typedef struct packed {
        logic o1;
        logic o2;
        logic err;
    } out_t;

    function automatic out_t out_code(input state_e st);
        out_t code;
        code = '0;
        case (st)
            S1:      code.o1  = 1'b1;
            S2:      code.o2  = 1'b1;
            ERROR:   code.err = 1'b1;
            default: code     = '0;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/sm_para_3_wdt_if.sv
// Protocol-side bundle of the FSM: stimulus inputs, decoded outputs and error status.
interface sm_para_3_wdt_if #(
    parameter int unsigned ERRCNT_W = 8
);
    logic                i1;
    logic                i2;
    logic                err_clr;
    logic                o1;
    logic                o2;
    logic                err;
    logic                err_to;
    logic [1:0]          state;
    logic [ERRCNT_W-1:0] err_cnt;

    modport master (
        output i1, i2, err_clr,
        input  o1, o2, err, err_to, state, err_cnt
    );

    modport slave (
        input  i1, i2, err_clr,
        output o1, o2, err, err_to, state, err_cnt
    );
endinterface

// File: rtl/sm_para_3_wdt_dwell_timer.sv
// Dwell counter for S1/S2; expired flags the last permitted cycle of occupancy.
module sm_dwell_timer #(
    parameter int unsigned TIMEOUT_W = 4,
    parameter int unsigned TIMEOUT   = 10
) (
    input  logic clk,
    input  logic nrst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam logic [TIMEOUT_W-1:0] DWELL_MAX   = '1;
    localparam logic [TIMEOUT_W-1:0] DWELL_LIMIT = TIMEOUT_W'(TIMEOUT - 1);
    localparam logic                 WDT_ON      = (TIMEOUT != 0);

    logic [TIMEOUT_W-1:0] r_dwell;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_dwell <= '0;
        end else if (clr) begin
            r_dwell <= '0;
        end else if (en && (r_dwell != DWELL_MAX)) begin
            r_dwell <= r_dwell + TIMEOUT_W'(1);
        end
    end

    assign expired = WDT_ON && (r_dwell == DWELL_LIMIT);

endmodule

// File: rtl/sm_para_3_wdt.sv
// i1/i2 protocol FSM with dwell watchdog on S1/S2, optional sticky error and saturating error counter.
module sm_para_3_wdt
    import sm_para_3_wdt_pkg::*;
#(
    parameter int unsigned TIMEOUT_W  = 4,
    parameter int unsigned TIMEOUT    = 10,
    parameter int unsigned STICKY_ERR = 0,
    parameter int unsigned ERRCNT_W   = 8
) (
    input  logic            clk,
    input  logic            nrst,
    sm_para_3_wdt_if.slave  bus
);
    localparam logic [ERRCNT_W-1:0] ERRCNT_MAX = '1;

    state_e              r_state;
    state_e              w_next;
    logic                w_timeout;
    logic                w_entry;
    logic                w_expired;
    logic                w_dwell_clr;
    logic                w_dwell_en;
    out_t                w_out;
    out_t                r_out;
    logic                r_err_to;
    logic [ERRCNT_W-1:0] r_err_cnt;

    assign w_dwell_clr = (w_next != r_state);
    assign w_dwell_en  = (r_state == S1) || (r_state == S2);

    sm_dwell_timer #(
        .TIMEOUT_W (TIMEOUT_W),
        .TIMEOUT   (TIMEOUT)
    ) u_dwell (
        .clk     (clk),
        .nrst    (nrst),
        .clr     (w_dwell_clr),
        .en      (w_dwell_en),
        .expired (w_expired)
    );

    // State register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; watchdog only overrides a "stay" decision
    always_comb begin
        w_next    = r_state;
        w_timeout = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.i1 && bus.i2)       w_next = S1;
                else if (bus.i1)            w_next = ERROR;
            end
            S1: begin
                if (bus.i2)                 w_next = bus.i1 ? S2 : ERROR;
            end
            S2: begin
                if (!bus.i2)                w_next = bus.i1 ? IDLE : ERROR;
            end
            ERROR: begin
                if (bus.err_clr)            w_next = IDLE;
                else if ((STICKY_ERR == 0) && !bus.i1) w_next = IDLE;
            end
            default:                        w_next = IDLE;
        endcase
        if (w_dwell_en && w_expired && (w_next == r_state)) begin
            w_next    = ERROR;
            w_timeout = 1'b1;
        end
        w_entry = (r_state != ERROR) && (w_next == ERROR);
        w_out   = out_code(w_next);
    end

    // Outputs decoded from next state so they move on the same edge as r_state
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_out    <= '0;
            r_err_to <= 1'b0;
        end else begin
            r_out <= w_out;
            if (w_entry)                r_err_to <= w_timeout;
            else if (w_next != ERROR)   r_err_to <= 1'b0;
        end
    end

    // Error-entry counter; a clear in the same cycle as an entry leaves the entry counted
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_err_cnt <= '0;
        end else if (bus.err_clr) begin
            r_err_cnt <= w_entry ? ERRCNT_W'(1) : '0;
        end else if (w_entry && (r_err_cnt != ERRCNT_MAX)) begin
            r_err_cnt <= r_err_cnt + ERRCNT_W'(1);
        end
    end

    assign bus.o1      = r_out.o1;
    assign bus.o2      = r_out.o2;
    assign bus.err     = r_out.err;
    assign bus.err_to  = r_err_to;
    assign bus.state   = 2'(r_state);
    assign bus.err_cnt = r_err_cnt;

endmodule
